// File: rtl/dtmr_mismatch_monitor_pkg.sv
// dtmr_pkg: lane-state type, lane count and the bitwise majority shared by the DTMR voters.
package dtmr_pkg;
  localparam int DTMR_LANES = 3;
  localparam int MAJ_W = 64;
  typedef enum logic [1:0] {LANE_OK, LANE_SUSPECT, LANE_FAULTY} lane_state_t;
  function automatic logic [MAJ_W-1:0] maj(input logic [MAJ_W-1:0] a, b, c);
    return (a & b) | (b & c) | (c & a);
  endfunction
endpackage

// File: rtl/dtmr_mismatch_monitor_if.sv
// dtmr_mismatch_monitor_if: triplicated sample bus in, voted word and fault status out.
interface dtmr_mismatch_monitor_if #(parameter int WIDTH = 8, parameter int CNT_W = 16);
  logic port_in_valid;
  logic [WIDTH-1:0] port_in_0;
  logic [WIDTH-1:0] port_in_1;
  logic [WIDTH-1:0] port_in_2;
  logic port_clear;
  logic [WIDTH-1:0] port_out;
  logic port_out_valid;
  logic [2:0] port_lane_mismatch;
  logic port_multi_mismatch;
  logic [2:0] port_lane_fault;
  logic [CNT_W-1:0] port_err_count;
  modport master (
    output port_in_valid, port_in_0, port_in_1, port_in_2, port_clear,
    input port_out, port_out_valid, port_lane_mismatch, port_multi_mismatch, port_lane_fault, port_err_count
  );
  modport slave (
    input port_in_valid, port_in_0, port_in_1, port_in_2, port_clear,
    output port_out, port_out_valid, port_lane_mismatch, port_multi_mismatch, port_lane_fault, port_err_count
  );
endinterface

// File: rtl/dtmr_mismatch_monitor_lane.sv
// dtmr_lane_monitor: per-lane OK/SUSPECT/FAULTY tracker over consecutive valid mismatches.
module dtmr_lane_monitor
  import dtmr_pkg::*;
#(
  parameter int THRESH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic mismatch,
  input  logic clear,
  output logic fault
);
  localparam logic [7:0] TH = 8'(THRESH);
  lane_state_t state;
  logic [7:0] cnt;
  // cnt is 0 in OK, so the same compare covers THRESH=1 jumping straight to FAULTY
  always_ff @(posedge clk)
    if (rst || clear) begin
      state <= LANE_OK;
      cnt <= '0;
      fault <= 1'b0;
    end else if (valid && state != LANE_FAULTY) begin
      if (!mismatch) begin
        state <= LANE_OK;
        cnt <= '0;
      end else if (cnt + 8'd1 >= TH) begin
        state <= LANE_FAULTY;
        cnt <= cnt + 8'd1;
        fault <= 1'b1;
      end else begin
        state <= LANE_SUSPECT;
        cnt <= cnt + 8'd1;
      end
    end
endmodule

// File: rtl/dtmr_mismatch_monitor.sv
// dtmr_mismatch_monitor: registered majority vote of three replica lanes with per-lane fault tracking.
module dtmr_mismatch_monitor
  import dtmr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int THRESH = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  dtmr_mismatch_monitor_if.slave bus
);
  logic [WIDTH-1:0] vote;
  logic [DTMR_LANES-1:0] mis;
  assign vote = WIDTH'(maj(MAJ_W'(bus.port_in_0), MAJ_W'(bus.port_in_1), MAJ_W'(bus.port_in_2)));
  assign mis = {bus.port_in_2 != vote, bus.port_in_1 != vote, bus.port_in_0 != vote};
  always_ff @(posedge clk)
    if (rst) begin
      bus.port_out <= '0;
      bus.port_out_valid <= 1'b0;
      bus.port_lane_mismatch <= '0;
      bus.port_multi_mismatch <= 1'b0;
      bus.port_err_count <= '0;
    end else begin
      bus.port_out_valid <= bus.port_in_valid;
      bus.port_lane_mismatch <= bus.port_in_valid ? mis : '0;
      bus.port_multi_mismatch <= bus.port_in_valid && $countones(mis) > 1;
      if (bus.port_in_valid) bus.port_out <= vote;
      if (bus.port_clear) bus.port_err_count <= '0;
      else if (bus.port_in_valid && |mis && bus.port_err_count != '1)
        bus.port_err_count <= bus.port_err_count + CNT_W'(1);
    end
  for (genvar i = 0; i < DTMR_LANES; i++) begin : g_lane
    dtmr_lane_monitor #(.THRESH(THRESH)) u_lane (
      .clk(clk),
      .rst(rst),
      .valid(bus.port_in_valid),
      .mismatch(mis[i]),
      .clear(bus.port_clear),
      .fault(bus.port_lane_fault[i])
    );
  end
endmodule

// File: tb/tb_dtmr_mismatch_monitor.sv
// tb_dtmr_mismatch_monitor: directed plan plus random traffic against a counting reference model.
module tb_dtmr_mismatch_monitor;
  localparam int W = 8;
  localparam int TH = 4;
  localparam int CW = 4;
  localparam int ERR_MAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int run [3];
  bit flt [3];
  int err;
  logic [W-1:0] m_out;
  bit m_ov, m_multi;
  logic [2:0] m_mis;
  always #5 clk = ~clk;
  dtmr_mismatch_monitor_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  dtmr_mismatch_monitor #(.WIDTH(W), .THRESH(TH), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model(input bit r, input bit v, input bit cl, input logic [W-1:0] a, b, c);
    logic [W-1:0] vt;
    logic [2:0] mis;
    if (r) begin
      m_out = '0; m_ov = 0; m_mis = '0; m_multi = 0; err = 0;
      for (int k = 0; k < 3; k++) begin run[k] = 0; flt[k] = 0; end
      return;
    end
    for (int k = 0; k < W; k++) vt[k] = (int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2;
    mis = {c != vt, b != vt, a != vt};
    m_ov = v;
    m_mis = v ? mis : 3'b000;
    m_multi = v && ($countones(mis) >= 2);
    if (v) m_out = vt;
    if (cl) begin
      err = 0;
      for (int k = 0; k < 3; k++) begin run[k] = 0; flt[k] = 0; end
    end else if (v) begin
      for (int k = 0; k < 3; k++)
        if (!flt[k]) begin
          run[k] = mis[k] ? run[k] + 1 : 0;
          if (run[k] >= TH) flt[k] = 1;
        end
      if (mis != 0 && err < ERR_MAX) err++;
    end
  endtask
  task automatic step(input bit r, input bit v, input bit cl, input logic [W-1:0] a, b, c);
    @(negedge clk);
    rst = r; bus.port_in_valid = v; bus.port_clear = cl;
    bus.port_in_0 = a; bus.port_in_1 = b; bus.port_in_2 = c;
    @(posedge clk);
    #1;
    model(r, v, cl, a, b, c);
    chk("out", 32'(bus.port_out), 32'(m_out));
    chk("out_valid", 32'(bus.port_out_valid), 32'(m_ov));
    chk("lane_mismatch", 32'(bus.port_lane_mismatch), 32'(m_mis));
    chk("multi", 32'(bus.port_multi_mismatch), 32'(m_multi));
    chk("lane_fault", 32'(bus.port_lane_fault), 32'({flt[2], flt[1], flt[0]}));
    chk("err_count", 32'(bus.port_err_count), 32'(err));
  endtask
  initial begin
    logic [W-1:0] a, b, c, base;
    bit r, v, cl;
    int k, stuck;
    bus.port_in_valid = 0; bus.port_clear = 0;
    bus.port_in_0 = '0; bus.port_in_1 = '0; bus.port_in_2 = '0;
    step(1, 0, 0, 8'h00, 8'h00, 8'h00);
    step(0, 1, 0, 8'hA5, 8'hA5, 8'hA5);
    step(0, 1, 0, 8'h3C, 8'h3C, 8'h3D);
    step(0, 1, 0, 8'h3C, 8'h3C, 8'h3C);
    step(0, 1, 0, 8'h00, 8'hFF, 8'h00);
    step(0, 1, 0, 8'h00, 8'hFF, 8'h00);
    step(0, 1, 0, 8'h00, 8'hFF, 8'h00);
    step(0, 0, 0, 8'h00, 8'hFF, 8'h00);
    step(0, 1, 0, 8'h00, 8'hFF, 8'h00);
    step(0, 1, 0, 8'h00, 8'h00, 8'h00);
    step(0, 1, 0, 8'h03, 8'h05, 8'h06);
    step(0, 0, 1, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h80, 8'h00, 8'h00);
    step(0, 1, 1, 8'h80, 8'h00, 8'h00);
    step(0, 1, 0, 8'h11, 8'h11, 8'h11);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 8'h00, 8'h00, 8'h7E);
    step(1, 1, 0, 8'h00, 8'h01, 8'h00);
    step(0, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 400; i++) begin
      stuck = (i / 50) % 4;
      r = $urandom_range(0, 149) == 0;
      v = $urandom_range(0, 3) != 0;
      cl = $urandom_range(0, 59) == 0;
      base = W'($urandom);
      a = base; b = base; c = base;
      k = $urandom_range(0, 7);
      if (k == 0) a = a ^ W'($urandom);
      else if (k == 1) b = b ^ W'($urandom);
      else if (k == 2) c = c ^ W'($urandom);
      else if (k == 3) begin a = W'($urandom); b = W'($urandom); c = W'($urandom); end
      if (stuck == 0 && $urandom_range(0, 4) != 0) a = ~base;
      if (stuck == 1 && $urandom_range(0, 4) != 0) b = base ^ 8'h01;
      if (stuck == 2 && $urandom_range(0, 4) != 0) c = base ^ 8'h80;
      step(r, v, cl, a, b, c);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
